// File: rtl/pr_freeze_seq.sv
// Freeze/port-reset sequencer for a partial-reconfiguration slot.
// On a freeze request it waits for every monitored AFU TX stream to reach a packet boundary.
// The wait is bounded by a timeout. It then freezes the slot and holds the ports in reset.
// On release it unfreezes the slot and keeps the port reset low for a fixed hold time.
module pr_freeze_seq #(
   parameter int unsigned PG_NUM_PORTS    = 1,
   parameter int unsigned DRAIN_TIMEOUT   = 4096,
   parameter int unsigned RST_HOLD_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    freeze_req,
   input  logic [PG_NUM_PORTS-1:0] tx_tvalid,
   input  logic [PG_NUM_PORTS-1:0] tx_tready,
   input  logic [PG_NUM_PORTS-1:0] tx_tlast,
   input  logic                    err_clr,
   output logic                    pr_freeze,
   output logic [PG_NUM_PORTS-1:0] port_rst_n,
   output logic                    freeze_ack,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int unsigned DrainW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
   localparam int unsigned HoldW  = (RST_HOLD_CYCLES > 0) ? $clog2(RST_HOLD_CYCLES + 1) : 1;
   localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_TIMEOUT - 1);
   localparam logic [HoldW-1:0]  HoldLast  = HoldW'(RST_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      StRstHold,
      StIdle,
      StDrain,
      StFrozen
   } state_e;

   state_e                  state_q, state_d;
   logic [DrainW-1:0]       drain_cnt_q, drain_cnt_d;
   logic [HoldW-1:0]        hold_cnt_q, hold_cnt_d;
   logic [PG_NUM_PORTS-1:0] in_pkt_q, in_pkt_d;
   logic                    pr_freeze_q, pr_freeze_d;
   logic [PG_NUM_PORTS-1:0] port_rst_n_q, port_rst_n_d;
   logic                    freeze_ack_q, freeze_ack_d;
   logic                    busy_q, busy_d;
   logic                    timeout_err_q, timeout_err_d;
   logic                    quiesced;
   logic                    timeout_set;

   // Per-port packet tracker; runs in every state so DRAIN starts from an accurate view.
   always_comb begin
      in_pkt_d = in_pkt_q;
      for (int i = 0; i < int'(PG_NUM_PORTS); i++) begin
         if (tx_tvalid[i] && tx_tready[i]) begin
            in_pkt_d[i] = ~tx_tlast[i];
         end
      end
   end

   // A port also counts as busy while it offers a beat, even one that would end a packet.
   assign quiesced = ~|in_pkt_q && ~|tx_tvalid;

   // Next-state logic, drain/hold counters, and registered outputs derived from the next state.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      timeout_set = 1'b0;

      unique case (state_q)
         StRstHold: begin
            if (hold_cnt_q == HoldLast) begin
               state_d = StIdle;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         StIdle: begin
            if (freeze_req) begin
               state_d     = StDrain;
               drain_cnt_d = '0;
            end
         end
         StDrain: begin
            if (!freeze_req) begin
               state_d = StIdle;
            end else if (quiesced) begin
               state_d = StFrozen;
            end else if (drain_cnt_q == DrainLast) begin
               state_d     = StFrozen;
               timeout_set = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         StFrozen: begin
            if (!freeze_req) begin
               state_d    = StRstHold;
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d = StRstHold;
         end
      endcase

      pr_freeze_d   = (state_d == StFrozen);
      freeze_ack_d  = (state_d == StFrozen);
      busy_d        = (state_d != StIdle);
      port_rst_n_d  = {PG_NUM_PORTS{(state_d == StIdle) || (state_d == StDrain)}};

      // A new timeout beats a coincident clear.
      if (timeout_set) begin
         timeout_err_d = 1'b1;
      end else if (err_clr) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end
   end

   // State, counters, trackers and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StRstHold;
         drain_cnt_q   <= '0;
         hold_cnt_q    <= '0;
         in_pkt_q      <= '0;
         pr_freeze_q   <= 1'b0;
         port_rst_n_q  <= '0;
         freeze_ack_q  <= 1'b0;
         busy_q        <= 1'b1;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         drain_cnt_q   <= drain_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         in_pkt_q      <= in_pkt_d;
         pr_freeze_q   <= pr_freeze_d;
         port_rst_n_q  <= port_rst_n_d;
         freeze_ack_q  <= freeze_ack_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign pr_freeze   = pr_freeze_q;
   assign port_rst_n  = port_rst_n_q;
   assign freeze_ack  = freeze_ack_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule
